// File: rtl/knn_classify_seq_if.sv
// Sample-stream and result bus of the streaming k-NN classifier.
// The master side drives the query, the samples and start; the slave side
// is the classifier, which returns in_ready and the sorted/voted result.
interface knn_classify_seq_if #(
    parameter int W  = 15,
    parameter int K  = 4,
    parameter int L  = 2,
    parameter int CW = 16
);
    logic             start;
    logic [W-1:0]     g_input;
    logic [W-1:0]     e_input;
    logic [L-1:0]     e_label;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [W*K-1:0]   o;
    logic [L-1:0]     o_label;
    logic [CW-1:0]    o_count;
    logic             o_valid;

    modport master (
        output start, g_input, e_input, e_label, in_valid, in_last,
        input  in_ready, o, o_label, o_count, o_valid
    );

    modport slave (
        input  start, g_input, e_input, e_label, in_valid, in_last,
        output in_ready, o, o_label, o_count, o_valid
    );
endinterface

// File: rtl/knn_classify_seq.sv
// Streaming k-nearest-neighbour classifier.
// Keeps the K accepted samples nearest (Hamming distance) to the query in a
// sorted slot array, then runs a K-cycle majority vote over the occupied slots.
// Slot 0 is the nearest; equal distances keep arrival order.
module knn_classify_seq #(
    parameter int W  = 15,
    parameter int K  = 4,
    parameter int L  = 2,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    knn_classify_seq_if.slave    bus
);
    localparam int LOGW = $clog2(W + 1);
    localparam int CNTW = $clog2(K + 1);
    localparam int CIW  = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        VOTE  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ready;

    logic [W-1:0]     r_val  [K];
    logic [LOGW-1:0]  r_dist [K];
    logic [L-1:0]     r_lab  [K];
    logic [K-1:0]     r_occ;

    logic [W-1:0]     w_val_nxt  [K];
    logic [LOGW-1:0]  w_dist_nxt [K];
    logic [L-1:0]     w_lab_nxt  [K];
    logic [K-1:0]     w_occ_nxt;

    logic [CW-1:0]    r_count;
    logic [L-1:0]     r_label;
    logic             r_valid;
    logic [CIW-1:0]   r_cand;
    logic [CNTW-1:0]  r_best_cnt;
    logic [L-1:0]     r_best_lab;

    logic             w_accept;
    logic [LOGW-1:0]  w_dist;
    int               w_pos;
    logic [CNTW-1:0]  w_vote_cnt;
    logic             w_vote_win;
    logic             w_cand_last;

    function automatic logic [LOGW-1:0] f_popcount(input logic [W-1:0] v);
        logic [LOGW-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            c = c + LOGW'(v[i]);
        end
        return c;
    endfunction

    assign w_accept    = r_ready && bus.in_valid && !bus.start;
    assign w_cand_last = (r_cand == CIW'(K - 1));

    // Next-state decode; start wins over any handshake in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.start) begin
            w_state_nxt = ACCUM;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = IDLE;
                ACCUM:   w_state_nxt = (w_accept && bus.in_last) ? VOTE : ACCUM;
                VOTE:    w_state_nxt = w_cand_last ? DONE : VOTE;
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State register and in_ready, which follows the ACCUM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == ACCUM);
        end
    end

    // Sorted insertion: find the position after all occupied slots that are
    // no farther than the new sample, shift the tail down, drop slot K-1.
    always_comb begin
        w_dist = f_popcount(bus.g_input ^ bus.e_input);
        w_pos  = 0;
        for (int j = 0; j < K; j++) begin
            if (r_occ[j] && (r_dist[j] <= w_dist)) begin
                w_pos = w_pos + 1;
            end else begin
                w_pos = w_pos;
            end
        end
        w_val_nxt  = r_val;
        w_dist_nxt = r_dist;
        w_lab_nxt  = r_lab;
        w_occ_nxt  = r_occ;
        if (w_pos == 0) begin
            w_val_nxt[0]  = bus.e_input;
            w_dist_nxt[0] = w_dist;
            w_lab_nxt[0]  = bus.e_label;
            w_occ_nxt[0]  = 1'b1;
        end else begin
            w_occ_nxt[0]  = r_occ[0];
        end
        for (int i = 1; i < K; i++) begin
            if (i == w_pos) begin
                w_val_nxt[i]  = bus.e_input;
                w_dist_nxt[i] = w_dist;
                w_lab_nxt[i]  = bus.e_label;
                w_occ_nxt[i]  = 1'b1;
            end else if (i > w_pos) begin
                w_val_nxt[i]  = r_val[i-1];
                w_dist_nxt[i] = r_dist[i-1];
                w_lab_nxt[i]  = r_lab[i-1];
                w_occ_nxt[i]  = r_occ[i-1];
            end else begin
                w_occ_nxt[i]  = r_occ[i];
            end
        end
    end

    // Vote step: how many occupied slots share the candidate's label.
    always_comb begin
        w_vote_cnt = '0;
        for (int j = 0; j < K; j++) begin
            if (r_occ[j] && (r_lab[j] == r_lab[r_cand])) begin
                w_vote_cnt = w_vote_cnt + CNTW'(1);
            end else begin
                w_vote_cnt = w_vote_cnt;
            end
        end
        w_vote_win = r_occ[r_cand] && (w_vote_cnt > r_best_cnt);
    end

    // Slot array, sample counter and vote registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                r_val[i]  <= '0;
                r_dist[i] <= '1;
                r_lab[i]  <= '0;
            end
            r_occ      <= '0;
            r_count    <= '0;
            r_label    <= '0;
            r_valid    <= 1'b0;
            r_cand     <= '0;
            r_best_cnt <= '0;
            r_best_lab <= '0;
        end else if (bus.start) begin
            for (int i = 0; i < K; i++) begin
                r_val[i]  <= '0;
                r_dist[i] <= '1;
                r_lab[i]  <= '0;
            end
            r_occ      <= '0;
            r_count    <= '0;
            r_label    <= '0;
            r_valid    <= 1'b0;
            r_cand     <= '0;
            r_best_cnt <= '0;
            r_best_lab <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_val  <= w_val_nxt;
                        r_dist <= w_dist_nxt;
                        r_lab  <= w_lab_nxt;
                        r_occ  <= w_occ_nxt;
                        if (r_count != '1) begin
                            r_count <= r_count + CW'(1);
                        end
                        if (bus.in_last) begin
                            r_cand     <= '0;
                            r_best_cnt <= '0;
                            r_best_lab <= '0;
                        end
                    end
                end
                VOTE: begin
                    r_cand <= r_cand + CIW'(1);
                    if (w_vote_win) begin
                        r_best_cnt <= w_vote_cnt;
                        r_best_lab <= r_lab[r_cand];
                    end
                    if (w_cand_last) begin
                        r_label <= w_vote_win ? r_lab[r_cand] : r_best_lab;
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < K; gi++) begin : g_out
        assign bus.o[W*gi +: W] = r_val[gi];
    end

    assign bus.in_ready = r_ready;
    assign bus.o_label  = r_label;
    assign bus.o_count  = r_count;
    assign bus.o_valid  = r_valid;
endmodule

// File: tb/tb_knn_classify_seq.sv
// Bench for knn_classify_seq: instance A (W=8,K=3,L=2,CW=16) covers the
// directed scenarios and random runs; instance B (W=15,K=4,L=2,CW=3) covers
// all-distance-W ties and sample-counter saturation.
module tb_knn_classify_seq;
    logic        clk;
    logic        rst;
    logic        start_a;
    logic        start_b;
    logic        valid_in;
    logic        last_in;
    logic [14:0] g_in;
    logic [14:0] e_in;
    logic [1:0]  lab_in;

    int n_vec = 0;
    int n_bad = 0;
    int q_e[$];
    int q_l[$];

    typedef struct {
        logic [7:0]  e;
        logic [1:0]  lab;
        logic        last;
        logic [23:0] exp_o;
        logic [15:0] exp_cnt;
    } vec_t;
    vec_t tbl[5];

    knn_classify_seq_if #(.W(8),  .K(3), .L(2), .CW(16)) bus_a ();
    knn_classify_seq_if #(.W(15), .K(4), .L(2), .CW(3))  bus_b ();

    assign bus_a.start    = start_a;
    assign bus_a.g_input  = g_in[7:0];
    assign bus_a.e_input  = e_in[7:0];
    assign bus_a.e_label  = lab_in;
    assign bus_a.in_valid = valid_in;
    assign bus_a.in_last  = last_in;

    assign bus_b.start    = start_b;
    assign bus_b.g_input  = g_in;
    assign bus_b.e_input  = e_in;
    assign bus_b.e_label  = lab_in;
    assign bus_b.in_valid = valid_in;
    assign bus_b.in_last  = last_in;

    knn_classify_seq #(.W(8),  .K(3), .L(2), .CW(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    knn_classify_seq #(.W(15), .K(4), .L(2), .CW(3))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] f_o(input int sel);
        return (sel == 0) ? 64'(bus_a.o) : 64'(bus_b.o);
    endfunction
    function automatic logic [63:0] f_lab(input int sel);
        return (sel == 0) ? 64'(bus_a.o_label) : 64'(bus_b.o_label);
    endfunction
    function automatic logic [63:0] f_cnt(input int sel);
        return (sel == 0) ? 64'(bus_a.o_count) : 64'(bus_b.o_count);
    endfunction
    function automatic logic [63:0] f_vld(input int sel);
        return (sel == 0) ? 64'(bus_a.o_valid) : 64'(bus_b.o_valid);
    endfunction
    function automatic logic [63:0] f_rdy(input int sel);
        return (sel == 0) ? 64'(bus_a.in_ready) : 64'(bus_b.in_ready);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_start(input int sel);
        if (sel == 0) start_a = 1'b1;
        else          start_b = 1'b1;
        cyc(1);
        start_a = 1'b0;
        start_b = 1'b0;
        q_e.delete();
        q_l.delete();
    endtask

    task automatic send(input int sel, input int e, input int lab, input bit last);
        e_in     = 15'(e);
        lab_in   = 2'(lab);
        last_in  = last;
        valid_in = 1'b1;
        chk("in_ready", f_rdy(sel), 64'd1);
        cyc(1);
        valid_in = 1'b0;
        last_in  = 1'b0;
        q_e.push_back(e);
        q_l.push_back(lab);
    endtask

    // Reference: stable selection of the K nearest accepted samples, then the
    // label with the largest count, ties going to the label seen nearest first.
    function automatic void model(input int sel, output logic [63:0] eo,
                                  output int elab, output int ecnt);
        int w;
        int k;
        int cmax;
        int mask;
        bit taken[64];
        int cnt[4];
        int first[4];
        int best;
        int bd;
        int d;
        w    = (sel == 0) ? 8 : 15;
        k    = (sel == 0) ? 3 : 4;
        cmax = (sel == 0) ? 65535 : 7;
        mask = (1 << w) - 1;
        eo   = 64'd0;
        for (int i = 0; i < 64; i++) taken[i] = 1'b0;
        for (int v = 0; v < 4; v++) begin
            cnt[v]   = 0;
            first[v] = 99;
        end
        for (int r = 0; r < k; r++) begin
            best = -1;
            bd   = 99;
            for (int i = 0; i < q_e.size(); i++) begin
                if (!taken[i]) begin
                    d = $countones((q_e[i] ^ int'(g_in)) & mask);
                    if (d < bd) begin
                        bd   = d;
                        best = i;
                    end
                end
            end
            if (best >= 0) begin
                taken[best] = 1'b1;
                eo = eo | (64'(q_e[best]) << (w * r));
                if (first[q_l[best]] == 99) first[q_l[best]] = r;
                cnt[q_l[best]]++;
            end
        end
        elab = 0;
        for (int v = 1; v < 4; v++) begin
            if ((cnt[v] > cnt[elab]) ||
                (cnt[v] == cnt[elab] && cnt[v] > 0 && first[v] < first[elab]))
                elab = v;
        end
        ecnt = (q_e.size() > cmax) ? cmax : q_e.size();
    endfunction

    task automatic check_result(input int sel, input string name);
        logic [63:0] eo;
        int elab;
        int ecnt;
        model(sel, eo, elab, ecnt);
        chk({name, ".o"},       f_o(sel),   eo);
        chk({name, ".o_label"}, f_lab(sel), 64'(elab));
        chk({name, ".o_count"}, f_cnt(sel), 64'(ecnt));
        chk({name, ".o_valid"}, f_vld(sel), 64'd1);
    endtask

    task automatic run_random(input int sel, input int n);
        int k;
        int mask;
        k    = (sel == 0) ? 3 : 4;
        mask = (sel == 0) ? 255 : 32767;
        g_in = 15'($urandom & mask);
        do_start(sel);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) cyc(1);
            send(sel, int'($urandom & mask), int'($urandom_range(0, 3)), (i == n - 1));
        end
        cyc(k);
        check_result(sel, (sel == 0) ? "rnd_a" : "rnd_b");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'hFF, 2'd0, 1'b0, 24'h0000FF, 16'd1};
        tbl[1] = '{8'h01, 2'd1, 1'b0, 24'h00FF01, 16'd2};
        tbl[2] = '{8'h03, 2'd1, 1'b0, 24'hFF0301, 16'd3};
        tbl[3] = '{8'h80, 2'd2, 1'b0, 24'h038001, 16'd4};
        tbl[4] = '{8'h07, 2'd0, 1'b1, 24'h038001, 16'd5};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        valid_in = 1'b0; last_in = 1'b0;
        g_in = '0; e_in = '0; lab_in = '0;
        cyc(3);
        for (int s = 0; s < 2; s++) begin
            chk("rst.o",        f_o(s),   64'd0);
            chk("rst.o_label",  f_lab(s), 64'd0);
            chk("rst.o_count",  f_cnt(s), 64'd0);
            chk("rst.o_valid",  f_vld(s), 64'd0);
            chk("rst.in_ready", f_rdy(s), 64'd0);
        end
        rst = 1'b0;
        cyc(1);

        // Sorted insertion with a tie, slot contents checked after every sample.
        g_in = 15'h0000;
        do_start(0);
        for (int i = 0; i < 5; i++) begin
            send(0, int'(tbl[i].e), int'(tbl[i].lab), tbl[i].last);
            chk("t1.o",       f_o(0),   64'(tbl[i].exp_o));
            chk("t1.o_count", f_cnt(0), 64'(tbl[i].exp_cnt));
        end
        cyc(1);
        chk("t1.valid_e1", f_vld(0), 64'd0);
        chk("t1.ready_e1", f_rdy(0), 64'd0);
        cyc(1);
        chk("t1.valid_e2", f_vld(0), 64'd0);
        cyc(1);
        chk("t1.valid_e3", f_vld(0), 64'd1);
        chk("t1.o_label",  f_lab(0), 64'd1);
        chk("t1.o_final",  f_o(0),   64'h038001);

        // Back-pressure: A sits in DONE, B in IDLE, in_valid held high.
        e_in = 15'h0055; lab_in = 2'd2; valid_in = 1'b1;
        cyc(3);
        valid_in = 1'b0;
        chk("bp.a_count", f_cnt(0), 64'd5);
        chk("bp.a_ready", f_rdy(0), 64'd0);
        chk("bp.a_valid", f_vld(0), 64'd1);
        chk("bp.a_o",     f_o(0),   64'h038001);
        chk("bp.b_count", f_cnt(1), 64'd0);
        chk("bp.b_ready", f_rdy(1), 64'd0);

        // Partial fill: two samples, slot 2 stays empty, tie goes to nearer.
        do_start(0);
        send(0, 8'h01, 2, 1'b0);
        send(0, 8'h03, 1, 1'b1);
        cyc(3);
        chk("pf.o",       f_o(0),   64'h000301);
        chk("pf.o_label", f_lab(0), 64'd2);
        chk("pf.o_count", f_cnt(0), 64'd2);
        chk("pf.o_valid", f_vld(0), 64'd1);

        // Abort and restart; the sample presented with start is dropped.
        do_start(0);
        send(0, 8'h33, 1, 1'b0);
        send(0, 8'h11, 0, 1'b0);
        start_a = 1'b1; e_in = 15'h00AA; lab_in = 2'd1; valid_in = 1'b1; last_in = 1'b1;
        cyc(1);
        start_a = 1'b0; valid_in = 1'b0; last_in = 1'b0;
        q_e.delete(); q_l.delete();
        chk("ab.count0", f_cnt(0), 64'd0);
        chk("ab.o0",     f_o(0),   64'd0);
        chk("ab.ready",  f_rdy(0), 64'd1);
        send(0, 8'h0F, 3, 1'b1);
        cyc(3);
        chk("ab.o",       f_o(0),   64'h00000F);
        chk("ab.o_label", f_lab(0), 64'd3);
        chk("ab.o_count", f_cnt(0), 64'd1);
        chk("ab.o_valid", f_vld(0), 64'd1);

        // start during VOTE aborts the vote.
        do_start(0);
        send(0, 8'h12, 1, 1'b1);
        do_start(0);
        cyc(4);
        chk("sv.o_valid", f_vld(0), 64'd0);
        chk("sv.o_count", f_cnt(0), 64'd0);
        chk("sv.ready",   f_rdy(0), 64'd1);
        send(0, 8'h01, 0, 1'b1);
        cyc(3);
        check_result(0, "sv");

        // All samples at distance W: arrival order kept, fifth discarded.
        g_in = 15'h0000;
        do_start(1);
        send(1, 15'h7FFF, 2, 1'b0);
        send(1, 15'h7FFF, 1, 1'b0);
        send(1, 15'h7FFF, 1, 1'b0);
        send(1, 15'h7FFF, 3, 1'b0);
        send(1, 15'h7FFF, 3, 1'b1);
        cyc(4);
        chk("sat.o",       f_o(1),   64'h0FFF_FFFF_FFFF_FFFF);
        chk("sat.o_label", f_lab(1), 64'd1);
        chk("sat.o_count", f_cnt(1), 64'd5);
        chk("sat.o_valid", f_vld(1), 64'd1);

        // Random runs; B also exercises o_count saturation at 7.
        for (int i = 0; i < 8; i++) run_random(1, 3 + i);
        for (int i = 0; i < 15; i++) run_random(0, int'($urandom_range(1, 8)));

        // Asynchronous reset between edges while A is voting.
        do_start(0);
        send(0, 8'h01, 1, 1'b1);
        cyc(1);
        rst = 1'b1;
        #1;
        chk("ar.o",       f_o(0),   64'd0);
        chk("ar.o_label", f_lab(0), 64'd0);
        chk("ar.o_count", f_cnt(0), 64'd0);
        chk("ar.o_valid", f_vld(0), 64'd0);
        chk("ar.ready",   f_rdy(0), 64'd0);
        chk("ar.b_o",     f_o(1),   64'd0);
        chk("ar.b_valid", f_vld(1), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        valid_in = 1'b1;
        cyc(2);
        valid_in = 1'b0;
        chk("ar.idle_count", f_cnt(0), 64'd0);
        chk("ar.idle_ready", f_rdy(0), 64'd0);
        chk("ar.idle_valid", f_vld(0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
